// File: rtl/traffic_pkg.sv
// Shared types and helpers for the multi-approach traffic intersection controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    CmdOn        = 3'b000,
    CmdOff       = 3'b001,
    CmdService   = 3'b010,
    CmdSetGreen  = 3'b011,
    CmdSetAllRed = 3'b100,
    CmdSetYellow = 3'b101
  } cmd_type_e;

  typedef logic [2:0] state_t;

  localparam state_t StOff        = 3'd0;
  localparam state_t StAllRed     = 3'd1;
  localparam state_t StRedYellow  = 3'd2;
  localparam state_t StGreen      = 3'd3;
  localparam state_t StGreenBlink = 3'd4;
  localparam state_t StYellow     = 3'd5;
  localparam state_t StService    = 3'd6;

  // A programmed 0 ms behaves as 1 ms so every state lasts at least one tick.
  function automatic logic [31:0] ms_to_cycles(input logic [31:0] ms, input int unsigned clk_khz);
    logic [31:0] m;
    m = (ms == 32'd0) ? 32'd1 : ms;
    return m * clk_khz;
  endfunction

endpackage

// File: rtl/tl_rr_pick.sv
// Round-robin selector: first requesting index after cur_i, with cur_i itself checked last.
module tl_rr_pick #(
  parameter int unsigned N_DIR = 2,
  localparam int unsigned IdxW = $clog2(N_DIR)
) (
  input  logic [N_DIR-1:0] req_i,
  input  logic [IdxW-1:0]  cur_i,
  output logic [IdxW-1:0]  nxt_o,
  output logic             valid_o
);

  logic [IdxW-1:0] idx;

  always_comb begin
    nxt_o   = cur_i;
    valid_o = 1'b0;
    idx     = '0;
    for (int unsigned i = 1; i <= N_DIR; i++) begin
      idx = IdxW'((32'(cur_i) + i) % N_DIR);
      if (!valid_o && req_i[idx]) begin
        nxt_o   = idx;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_intersection.sv
// Sequences N_DIR signal heads: one green approach at a time, all-red clearance between
// phases, programmable timing and an optional demand-driven skip of idle approaches.
module traffic_intersection
  import traffic_pkg::*;
#(
  parameter int unsigned N_DIR                 = 2,
  parameter int unsigned CLK_KHZ               = 2,
  parameter int unsigned BLINK_HALF_PERIOD_MS  = 4,
  parameter int unsigned BLINK_GREEN_TIME_TICK = 2,
  parameter int unsigned RED_YELLOW_MS         = 10,
  parameter int unsigned DEMAND_EN             = 0,
  parameter int unsigned DEF_GREEN_MS          = 50,
  parameter int unsigned DEF_YELLOW_MS         = 30,
  parameter int unsigned DEF_ALL_RED_MS        = 10,
  localparam int unsigned DirW = $clog2(N_DIR)
) (
  input  logic             clk_i,
  input  logic             arstn_i,
  input  logic             cmd_valid_i,
  input  logic [2:0]       cmd_type_i,
  input  logic [DirW-1:0]  cmd_dir_i,
  input  logic [15:0]      cmd_data_i,
  input  logic [N_DIR-1:0] demand_i,
  output logic [N_DIR-1:0] red_o,
  output logic [N_DIR-1:0] yellow_o,
  output logic [N_DIR-1:0] green_o,
  output logic [DirW-1:0]  active_dir_o
);

  localparam logic [31:0] RyCyc         = ms_to_cycles(32'(RED_YELLOW_MS), CLK_KHZ);
  localparam logic [31:0] BlinkHalf     = ms_to_cycles(32'(BLINK_HALF_PERIOD_MS), CLK_KHZ);
  localparam logic [31:0] BlinkPeriod   = 2 * BlinkHalf;
  localparam logic [31:0] GreenBlinkCyc = BlinkPeriod * BLINK_GREEN_TIME_TICK;
  localparam logic [DirW-1:0] LastDir   = DirW'(N_DIR - 1);

  state_t            state_q, state_d;
  logic [31:0]       cnt_q, cnt_d, blink_q, blink_d, dur;
  logic [DirW-1:0]   dir_q, dir_d, pick_dir;
  logic [15:0]       green_ms_q [N_DIR];
  logic [15:0]       green_ms_d [N_DIR];
  logic [15:0]       yellow_ms_q, yellow_ms_d, all_red_ms_q, all_red_ms_d;
  logic [N_DIR-1:0]  demand_q, demand_d, req, act_oh, clr_oh;
  logic              done, pick_valid, blink_on, cmd_on, cmd_off, cmd_srv;

  assign req = (DEMAND_EN != 0) ? demand_q : '1;

  tl_rr_pick #(.N_DIR(N_DIR)) u_rr_pick (
    .req_i   (req),
    .cur_i   (dir_q),
    .nxt_o   (pick_dir),
    .valid_o (pick_valid)
  );

  always_comb begin
    unique case (state_q)
      StAllRed:     dur = ms_to_cycles({16'd0, all_red_ms_q}, CLK_KHZ);
      StRedYellow:  dur = RyCyc;
      StGreen:      dur = ms_to_cycles({16'd0, green_ms_q[dir_q]}, CLK_KHZ);
      StGreenBlink: dur = GreenBlinkCyc;
      StYellow:     dur = ms_to_cycles({16'd0, yellow_ms_q}, CLK_KHZ);
      default:      dur = 32'd1;
    endcase
  end

  assign done    = (cnt_q == dur - 32'd1);
  assign cmd_on  = cmd_valid_i && (cmd_type_i == CmdOn);
  assign cmd_off = cmd_valid_i && (cmd_type_i == CmdOff);
  assign cmd_srv = cmd_valid_i && (cmd_type_i == CmdService);

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    if (cmd_off) begin
      state_d = StOff;
    end else if (cmd_srv && state_q != StOff) begin
      state_d = StService;
    end else begin
      case (state_q)
        StOff, StService: if (cmd_on) begin
          state_d = StAllRed;
          dir_d   = LastDir;
        end
        // Without a pick the counter parks at terminal until demand shows up.
        StAllRed: if (done && pick_valid) begin
          state_d = StRedYellow;
          dir_d   = pick_dir;
        end
        StRedYellow:  if (done) state_d = StGreen;
        StGreen:      if (done) state_d = (GreenBlinkCyc != 32'd0) ? StGreenBlink : StYellow;
        StGreenBlink: if (done) state_d = StYellow;
        StYellow:     if (done) state_d = StAllRed;
        default:      state_d = StAllRed;
      endcase
    end
  end

  always_comb begin
    if (state_d != state_q) cnt_d = '0;
    else if (!done)         cnt_d = cnt_q + 32'd1;
    else                    cnt_d = cnt_q;

    if (state_d != state_q && (state_d == StGreenBlink || state_d == StService)) blink_d = '0;
    else if (blink_q >= BlinkPeriod - 32'd1)                                     blink_d = '0;
    else                                                                         blink_d = blink_q + 32'd1;
  end

  assign blink_on = (blink_q < BlinkHalf);

  // A pulse coinciding with the clear keeps the latch set.
  always_comb begin
    clr_oh = '0;
    clr_oh[dir_q] = (state_q == StRedYellow) && (state_d == StGreen);
    demand_d = (demand_q & ~clr_oh) | demand_i;
  end

  always_comb begin
    green_ms_d   = green_ms_q;
    yellow_ms_d  = yellow_ms_q;
    all_red_ms_d = all_red_ms_q;
    if (cmd_valid_i && state_q == StService) begin
      case (cmd_type_i)
        CmdSetGreen:  if (32'(cmd_dir_i) < N_DIR) green_ms_d[cmd_dir_i] = cmd_data_i;
        CmdSetAllRed: all_red_ms_d = cmd_data_i;
        CmdSetYellow: yellow_ms_d = cmd_data_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q      <= StAllRed;
      dir_q        <= LastDir;
      cnt_q        <= '0;
      blink_q      <= '0;
      demand_q     <= '0;
      yellow_ms_q  <= 16'(DEF_YELLOW_MS);
      all_red_ms_q <= 16'(DEF_ALL_RED_MS);
      for (int i = 0; i < N_DIR; i++) green_ms_q[i] <= 16'(DEF_GREEN_MS);
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      cnt_q        <= cnt_d;
      blink_q      <= blink_d;
      demand_q     <= demand_d;
      yellow_ms_q  <= yellow_ms_d;
      all_red_ms_q <= all_red_ms_d;
      green_ms_q   <= green_ms_d;
    end
  end

  always_comb begin
    act_oh = '0;
    act_oh[dir_q] = 1'b1;
    red_o    = '0;
    yellow_o = '0;
    green_o  = '0;
    unique case (state_q)
      StOff: ;
      StService: yellow_o = {N_DIR{blink_on}};
      StAllRed:  red_o = '1;
      StRedYellow: begin
        red_o    = '1;
        yellow_o = act_oh;
      end
      StGreen: begin
        red_o   = ~act_oh;
        green_o = act_oh;
      end
      StGreenBlink: begin
        red_o   = ~act_oh;
        green_o = blink_on ? act_oh : '0;
      end
      StYellow: begin
        red_o    = ~act_oh;
        yellow_o = act_oh;
      end
      default: red_o = '1;
    endcase
  end

  assign active_dir_o = dir_q;

endmodule

// File: tb/tb_traffic_intersection.sv
// Self-checking bench: segment tables of expected lamp patterns fed through a scoreboard queue.
module tb_traffic_intersection;
  import traffic_pkg::*;

  logic       clk = 1'b0;
  logic       arstn;
  logic       cmd_valid;
  logic [2:0] cmd_type;
  logic       cmd_dir;
  logic [15:0] cmd_data;
  logic [1:0] demand;
  logic [1:0] r1, y1, g1;
  logic       d1;

  logic       cmd2_valid;
  logic [2:0] cmd2_type;
  logic       cmd2_dir;
  logic [15:0] cmd2_data;
  logic [1:0] demand2;
  logic [1:0] r2, y2, g2;
  logic       d2;

  always #5 clk = ~clk;

  traffic_intersection #(.N_DIR(2), .CLK_KHZ(2), .DEMAND_EN(0)) u_dut (
    .clk_i(clk), .arstn_i(arstn), .cmd_valid_i(cmd_valid), .cmd_type_i(cmd_type),
    .cmd_dir_i(cmd_dir), .cmd_data_i(cmd_data), .demand_i(demand),
    .red_o(r1), .yellow_o(y1), .green_o(g1), .active_dir_o(d1)
  );

  traffic_intersection #(.N_DIR(2), .CLK_KHZ(2), .DEMAND_EN(1)) u_dut_dem (
    .clk_i(clk), .arstn_i(arstn), .cmd_valid_i(cmd2_valid), .cmd_type_i(cmd2_type),
    .cmd_dir_i(cmd2_dir), .cmd_data_i(cmd2_data), .demand_i(demand2),
    .red_o(r2), .yellow_o(y2), .green_o(g2), .active_dir_o(d2)
  );

  typedef struct {
    string      name;
    logic [1:0] red;
    logic [1:0] yel;
    logic [1:0] grn;
    logic       dir;
    int         n;
  } seg_t;

  typedef struct packed {
    logic [1:0] red;
    logic [1:0] yel;
    logic [1:0] grn;
    logic       dir;
  } lamp_t;

  seg_t  plan[$];
  lamp_t sb[$];
  int    errors = 0;
  int    checks = 0;

  function automatic logic [1:0] oh(input int d);
    logic [1:0] v;
    v = 2'b01 << d;
    return v;
  endfunction

  task automatic check_now(input int sel, input string name, input lamp_t exp);
    lamp_t got, want;
    sb.push_back(exp);
    if (sel == 0) got = {r1, y1, g1, d1};
    else          got = {r2, y2, g2, d2};
    want = sb.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t dut%0d: got r=%b y=%b g=%b dir=%0d, want r=%b y=%b g=%b dir=%0d",
               name, $time, sel, got.red, got.yel, got.grn, got.dir,
               want.red, want.yel, want.grn, want.dir);
    end
  endtask

  task automatic add(input string nm, input logic [1:0] r, input logic [1:0] y,
                     input logic [1:0] g, input int d, input int n);
    seg_t s;
    s.name = nm; s.red = r; s.yel = y; s.grn = g; s.dir = d[0]; s.n = n;
    plan.push_back(s);
  endtask

  task automatic add_allred(input int d, input int n); add("allred", 2'b11, 2'b00, 2'b00, d, n); endtask
  task automatic add_ry(input int d, input int n);     add("redyel", 2'b11, oh(d), 2'b00, d, n); endtask
  task automatic add_green(input int d, input int n);  add("green", ~oh(d), 2'b00, oh(d), d, n); endtask
  task automatic add_yellow(input int d, input int n); add("yellow", ~oh(d), oh(d), 2'b00, d, n); endtask

  task automatic add_blink(input int d);
    for (int p = 0; p < 2; p++) begin
      add("blink_on", ~oh(d), 2'b00, oh(d), d, 8);
      add("blink_off", ~oh(d), 2'b00, 2'b00, d, 8);
    end
  endtask

  // Applies the table one sample per cycle, sampling 1 time unit after each rising edge.
  task automatic run_plan(input int sel);
    lamp_t e;
    foreach (plan[i]) begin
      for (int k = 0; k < plan[i].n; k++) begin
        e = {plan[i].red, plan[i].yel, plan[i].grn, plan[i].dir};
        check_now(sel, plan[i].name, e);
        @(posedge clk); #1;
      end
    end
    plan.delete();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] t, input logic d, input logic [15:0] data);
    cmd_type = t; cmd_dir = d; cmd_data = data; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    arstn = 1'b0;
    cmd_valid = 1'b0;
    demand = 2'b00;
    demand2 = 2'b00;
    @(posedge clk); #1;
    arstn = 1'b1;
  endtask

  initial begin
    arstn = 1'b0; cmd_valid = 1'b0; cmd_type = 3'b000; cmd_dir = 1'b0; cmd_data = 16'd0;
    demand = 2'b00; cmd2_valid = 1'b0; cmd2_type = 3'b000; cmd2_dir = 1'b0;
    cmd2_data = 16'd0; demand2 = 2'b00;

    // Default round-robin cycle through both approaches.
    do_reset();
    add_allred(1, 20); add_ry(0, 20); add_green(0, 100); add_blink(0); add_yellow(0, 60);
    add_allred(0, 20); add_ry(1, 20); add_green(1, 100); add_blink(1); add_yellow(1, 60);
    add_allred(1, 20); add_ry(0, 1);
    run_plan(0);

    // Service mode abort, reprogram dir1 green, resume.
    do_reset();
    wait_cycles(40);
    add_green(0, 5);
    run_plan(0);
    send_cmd(CmdService, 1'b0, 16'd0);
    add("svc_on", 2'b00, 2'b11, 2'b00, 0, 8); add("svc_off", 2'b00, 2'b00, 2'b00, 0, 8);
    add("svc_on", 2'b00, 2'b11, 2'b00, 0, 8);
    run_plan(0);
    send_cmd(CmdSetGreen, 1'b1, 16'd5);
    send_cmd(CmdOn, 1'b0, 16'd0);
    add_allred(1, 20); add_ry(0, 20); add_green(0, 100); add_blink(0); add_yellow(0, 60);
    add_allred(0, 20); add_ry(1, 20); add_green(1, 10); add("blink_on", 2'b01, 2'b00, 2'b10, 1, 1);
    run_plan(0);

    // Set-green outside service is ignored.
    do_reset();
    add_allred(1, 20); add_ry(0, 20); add_green(0, 10);
    run_plan(0);
    send_cmd(CmdSetGreen, 1'b1, 16'd5);
    add_green(0, 89); add_blink(0); add_yellow(0, 60); add_allred(0, 20); add_ry(1, 20);
    add_green(1, 100); add("blink_on", 2'b01, 2'b00, 2'b10, 1, 1);
    run_plan(0);

    // Demand-driven instance: hold all-red, then serve only dir1.
    do_reset();
    add_allred(1, 200);
    run_plan(1);
    demand2 = 2'b10;
    @(posedge clk); #1;
    demand2 = 2'b00;
    add_allred(1, 1); add_ry(1, 20); add_green(1, 100); add_blink(1); add_yellow(1, 60);
    add_allred(1, 100);
    run_plan(1);

    // OFF mid-yellow, ON again, then async reset mid-green.
    do_reset();
    wait_cycles(172);
    add_yellow(0, 5);
    run_plan(0);
    send_cmd(CmdOff, 1'b0, 16'd0);
    add("off", 2'b00, 2'b00, 2'b00, 0, 10);
    run_plan(0);
    send_cmd(CmdOn, 1'b0, 16'd0);
    add_allred(1, 20); add_ry(0, 20); add_green(0, 10);
    run_plan(0);
    #2 arstn = 1'b0;
    #1 check_now(0, "async_rst", {2'b11, 2'b00, 2'b00, 1'b1});

    // Zero yellow clamps to 1 ms; 1 ms all-red; undefined code ignored in service.
    do_reset();
    send_cmd(CmdService, 1'b0, 16'd0);
    send_cmd(CmdSetYellow, 1'b0, 16'd0);
    send_cmd(CmdSetAllRed, 1'b0, 16'd1);
    send_cmd(3'b110, 1'b0, 16'd0);
    check_now(0, "svc_hold", {2'b00, 2'b11, 2'b00, 1'b1});
    send_cmd(CmdOn, 1'b0, 16'd0);
    add_allred(1, 2); add_ry(0, 20);
    run_plan(0);
    wait_cycles(132);
    add_yellow(0, 2); add_allred(0, 2); add_ry(1, 1);
    run_plan(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/traffic_intersection.md
Name: traffic_intersection

Overview:
Parametrised multi-approach successor to the single-head traffic light. It sequences N_DIR signal heads around one intersection:
- Exactly one approach gets a green phase at a time.
- An all-red clearance interval separates consecutive phases.
- Green time is programmable per approach.
- Optional vehicle-demand inputs let approaches with no traffic be skipped.
- The command interface and service (yellow-blink) mode match the single-head block.

Parameters:
N_DIR, 2, number of approaches (>=2)
CLK_KHZ, 2, clock frequency in kHz; 1 ms = CLK_KHZ cycles
BLINK_HALF_PERIOD_MS, 4, blink half period in ms
BLINK_GREEN_TIME_TICK, 2, number of green blink periods; 0 disables GREEN_BLINK
RED_YELLOW_MS, 10, red+yellow duration in ms
DEMAND_EN, 0, 1 = skip approaches with no latched demand; 0 = fixed round-robin
DEF_GREEN_MS, 50, reset green time for every approach
DEF_YELLOW_MS, 30, reset yellow time
DEF_ALL_RED_MS, 10, reset all-red clearance time

Ports:
clk_i  in  1  clock
arstn_i  in  1  asynchronous active-low reset
cmd_valid_i  in  1  command strobe
cmd_type_i  in  3  000 ON, 001 OFF, 010 SERVICE, 011 set green, 100 set all-red, 101 set yellow
cmd_dir_i  in  $clog2(N_DIR)  target approach for the set-green command
cmd_data_i  in  16  time value in ms
demand_i  in  N_DIR  vehicle detector pulse per approach
red_o  out  N_DIR  red lamp per approach
yellow_o  out  N_DIR  yellow lamp per approach
green_o  out  N_DIR  green lamp per approach
active_dir_o  out  $clog2(N_DIR)  approach currently owning the phase

Behaviour:
- Reset (async assert, sync release):
  - state = ALL_RED, active_dir = N_DIR-1, so dir0 is served first.
  - Time registers load their defaults; demand latches clear.
  - Outputs during reset: red_o = all 1, yellow_o = 0, green_o = 0, active_dir_o = N_DIR-1.
- Outputs are decoded from registered state/counters only; there is no combinational path from any input to any lamp.
- States: OFF, ALL_RED, RED_YELLOW, GREEN, GREEN_BLINK, YELLOW, SERVICE.
- Durations are in cycles, ms*CLK_KHZ, counted by a 32-bit state counter cleared on every state entry.
  - A state lasts exactly its duration; the transition fires on the cycle where count == duration-1.
  - A programmed value of 0 ms is treated as 1 ms.
- Phase sequence:
  - ALL_RED(all_red_ms) -> RED_YELLOW(RED_YELLOW_MS) -> GREEN(green_ms[active_dir]) -> GREEN_BLINK(2*BLINK_HALF_PERIOD_MS*BLINK_GREEN_TIME_TICK) -> YELLOW(yellow_ms) -> ALL_RED.
  - If BLINK_GREEN_TIME_TICK = 0, GREEN goes straight to YELLOW.
- Lamps:
  - The active approach shows red+yellow in RED_YELLOW, green in GREEN, blinking green in GREEN_BLINK, and yellow in YELLOW.
  - Every other approach shows red in all of these states.
- Blink counter:
  - Period 2*BLINK_HALF_PERIOD_MS*CLK_KHZ cycles; cleared on entry to GREEN_BLINK or SERVICE.
  - Lamp is ON in the first half of each period, OFF in the second.
- End of ALL_RED, next-direction selection:
  - DEMAND_EN = 0: active_dir <= (active_dir+1) mod N_DIR, always.
  - DEMAND_EN = 1: pick the first approach with latched demand, searching from active_dir+1 round-robin (active_dir itself is checked last). If no demand is latched, stay in ALL_RED (counter held at terminal) until one appears.
- Demand latch:
  - Set by a demand_i pulse; cleared on entry to GREEN for that approach.
  - A pulse arriving in the same cycle as the clear wins, so the latch stays set.
- OFF: all lamps 0. SERVICE: red/green = 0, yellow_o = all approaches blinking in phase.
- Commands, single cycle on cmd_valid_i. Precedence within the next-state logic: OFF > SERVICE > state-specific logic.
  - OFF (from any state) -> OFF.
  - SERVICE (from any state except OFF) -> SERVICE.
  - ON (from OFF or SERVICE only) -> ALL_RED with active_dir = N_DIR-1, counter cleared. Ignored elsewhere.
  - Set-green, set-all-red and set-yellow are accepted only in SERVICE; they update the register on the next edge.
  - Set-green with cmd_dir_i >= N_DIR is ignored.
  - Undefined codes 110 and 111 are ignored.
- A command mid-phase aborts the phase immediately (next cycle); timing is not completed.

Decomposition:
- Package traffic_pkg holds:
  - the cmd_type enum;
  - the state enum, 3 bits;
  - the ms-to-cycle conversion function, which includes the 0 -> 1 clamp.
- Sub-module tl_rr_pick (combinational, parametrised by N_DIR):
  - inputs: request vector and current index;
  - outputs: next index and any-valid flag.
  - Used with request = all-ones when DEMAND_EN = 0.

Test Plan:
Common setup: N_DIR=2, CLK_KHZ=2, DEMAND_EN=0, defaults as listed.
1. Release reset -> red_o=11 for 20 cyc; dir0 red+yellow 20 cyc; green 100 cyc; blink 32 cyc (8 on/8 off, 2 periods); yellow 60 cyc; red_o=11 for 20 cyc; then dir1 RED_YELLOW, active_dir_o=1.
2. SERVICE in dir0 GREEN, then set-green dir1 data=5, then ON -> yellow_o=11 blinking 8/8 cyc during SERVICE; after ON, dir0 green lasts 100 cyc and dir1 green lasts 10 cyc.
3. Set-green issued while in GREEN (not SERVICE) -> no change; following dir1 green still lasts 100 cyc.
4. DEMAND_EN=1, no demand -> holds red_o=11 indefinitely. demand_i[1] pulse -> dir1 RED_YELLOW begins 1 cycle after the pulse is latched; dir0 is never served.
5. OFF mid-YELLOW -> all lamps 0 next cycle. Async reset asserted mid-GREEN -> red_o=11 immediately, without waiting for a clock edge.
6. cmd_data_i=0 for yellow, then ON -> YELLOW lasts exactly 2 cycles.
